// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : N-port round-robin arbiter in front of one shared memory port,
//            with abort-on-enable-drop and optional per-transaction timeout.
// Revision : 1.0
// ============================================================================
module memory_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             port_enable,
    input  logic [NUM_PORTS-1:0]             port_command,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_data,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_write_mask,
    output logic [DATA_WIDTH-1:0]            port_read_data,
    output logic [NUM_PORTS-1:0]             port_valid,
    output logic [NUM_PORTS-1:0]             port_error,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy,
    output logic                             mem_enable,
    output logic                             mem_command,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
    output logic [MASK_WIDTH-1:0]            mem_write_mask,
    input  logic [DATA_WIDTH-1:0]            mem_read_data,
    input  logic                             mem_valid
);

    localparam int c_IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   r_last;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
    logic [MASK_WIDTH-1:0] w_wmask [NUM_PORTS];
    logic [c_IDX_W-1:0]    w_win;
    logic [c_IDX_W-1:0]    w_cand;
    logic                  w_busy;
    logic                  w_own_en;
    logic                  w_to_hit;
    logic                  w_done;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign w_addr[gi]  = port_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = port_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_wmask[gi] = port_write_mask[gi*MASK_WIDTH +: MASK_WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest after r_last so the nearest requester wins.
    always_comb begin
        w_win  = r_last;
        w_cand = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_cand = c_IDX_W'((int'(r_last) + k) % NUM_PORTS);
            if (port_enable[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    assign w_busy   = (r_state == S_BUSY);
    assign w_own_en = port_enable[r_owner];
    assign w_done   = w_busy & (mem_valid | ~w_own_en | w_to_hit);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int c_CNT_W = $clog2(TIMEOUT + 1);
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (!w_busy) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_to_hit = w_busy && (r_cnt == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_to_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= c_IDX_W'(NUM_PORTS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|port_enable) begin
                        r_state <= S_BUSY;
                        r_owner <= w_win;
                        r_grant <= NUM_PORTS'(1) << w_win;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant          = r_grant;
    assign busy           = w_busy;
    assign port_read_data = mem_read_data;
    assign mem_enable     = w_busy & w_own_en;
    assign mem_command    = w_busy ? port_command[r_owner] : 1'b0;
    assign mem_address    = w_busy ? w_addr[r_owner]  : '0;
    assign mem_write_data = w_busy ? w_wdata[r_owner] : '0;
    assign mem_write_mask = w_busy ? w_wmask[r_owner] : '0;
    // A valid arriving on the timeout cycle takes precedence over the error.
    assign port_valid     = (w_busy && mem_valid) ? r_grant : '0;
    assign port_error     = (w_busy && w_to_hit && !mem_valid) ? r_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Self-checking bench for memory_arbiter (4 ports, timeout 5).
// Revision : 1.0
// ============================================================================
module tb_memory_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP-1:0]    port_enable;
    logic [NP-1:0]    port_command;
    logic [NP*AW-1:0] port_address;
    logic [NP*DW-1:0] port_write_data;
    logic [NP*MW-1:0] port_write_mask;
    logic [DW-1:0]    port_read_data;
    logic [NP-1:0]    port_valid;
    logic [NP-1:0]    port_error;
    logic [NP-1:0]    grant;
    logic             busy;
    logic             mem_enable;
    logic             mem_command;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_write_data;
    logic [MW-1:0]    mem_write_mask;
    logic [DW-1:0]    mem_read_data;
    logic             mem_valid;

    memory_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MASK_WIDTH(MW),
        .TIMEOUT   (5)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .port_enable    (port_enable),
        .port_command   (port_command),
        .port_address   (port_address),
        .port_write_data(port_write_data),
        .port_write_mask(port_write_mask),
        .port_read_data (port_read_data),
        .port_valid     (port_valid),
        .port_error     (port_error),
        .grant          (grant),
        .busy           (busy),
        .mem_enable     (mem_enable),
        .mem_command    (mem_command),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_mask (mem_write_mask),
        .mem_read_data  (mem_read_data),
        .mem_valid      (mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] valid;
        logic [NP-1:0] err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int            port;
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
        int            lat;
        logic [DW-1:0] rdata;
        logic [NP-1:0] exp_grant;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion/error monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (port_valid != '0 || port_error != '0)) begin
            chk("valid_error_onehot", 64'($onehot({port_valid, port_error})), 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_completion", {port_valid, port_error}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("port_valid", port_valid, e.valid);
                chk("port_error", port_error, e.err);
                if (e.valid != '0) chk("port_read_data", port_read_data, e.rdata);
            end
        end
    end

    task automatic wait_mem_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_mem_enable", 64'd0, 64'd1);
    endtask

    // Valid is raised in the lat-th BUSY cycle after the one where mem_enable was seen.
    task automatic serve(input int lat, input logic [DW-1:0] rd, input logic [NP-1:0] g);
        repeat (lat) @(posedge clk);
        #1;
        mem_valid     = 1'b1;
        mem_read_data = rd;
        sb.push_back('{valid: g, err: '0, rdata: rd});
        @(posedge clk);
        #1;
        mem_valid     = 1'b0;
        mem_read_data = 32'h0BAD_BEEF;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   ok;

        vecs[0] = '{1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'b0000, 3, 32'h1234_5678, 4'b0010};
        vecs[1] = '{0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 1, 32'h0000_0000, 4'b0001};
        vecs[2] = '{3, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 4'b1111, 2, 32'h5555_AAAA, 4'b1000};
        vecs[3] = '{2, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0100, 1, 32'hCAFE_F00D, 4'b0100};

        reset_n       = 1'b0;
        port_enable   = '0;
        mem_valid     = 1'b0;
        mem_read_data = 32'h0BAD_BEEF;
        for (int p = 0; p < NP; p++) begin
            port_command[p]              = p[0];
            port_address[p*AW +: AW]     = 32'hBAD0_0000 | p;
            port_write_data[p*DW +: DW]  = 32'h7700_0000 | p;
            port_write_mask[p*MW +: MW]  = 4'(p + 5);
        end

        apply_reset();
        @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mem_enable", mem_enable, 0);
        chk("reset_mem_address", mem_address, 0);
        chk("reset_mem_write_data", mem_write_data, 0);

        // Single-transaction vectors: bubble, forwarding and routed completion.
        for (int v = 0; v < 4; v++) begin
            @(posedge clk);
            #1;
            port_command[vecs[v].port]                 = vecs[v].cmd;
            port_address[vecs[v].port*AW +: AW]        = vecs[v].addr;
            port_write_data[vecs[v].port*DW +: DW]     = vecs[v].wdata;
            port_write_mask[vecs[v].port*MW +: MW]     = vecs[v].mask;
            port_enable[vecs[v].port]                  = 1'b1;
            @(negedge clk);
            chk("bubble_mem_enable", mem_enable, 0);
            chk("bubble_grant", grant, 0);
            wait_mem_en(ok);
            if (ok) begin
                chk("vec_grant", grant, vecs[v].exp_grant);
                chk("vec_busy", busy, 1);
                chk("vec_mem_address", mem_address, vecs[v].addr);
                chk("vec_mem_command", mem_command, vecs[v].cmd);
                chk("vec_mem_write_data", mem_write_data, vecs[v].wdata);
                chk("vec_mem_write_mask", mem_write_mask, vecs[v].mask);
                serve(vecs[v].lat, vecs[v].rdata, vecs[v].exp_grant);
            end
            port_enable = '0;
            @(negedge clk);
            chk("post_txn_grant", grant, 0);
            chk("post_txn_busy", busy, 0);
        end

        // Contention: all four ports held, round-robin from port 0.
        apply_reset();
        port_enable = 4'hF;
        for (int t = 0; t < 8; t++) begin
            wait_mem_en(ok);
            if (ok) begin
                chk("rr_grant", grant, 64'(4'b0001 << (t % 4)));
                serve(1 + (t % 3), 32'h1000_0000 + t, 4'(4'b0001 << (t % 4)));
            end
        end
        port_enable = '0;

        // Abort: port 2 drops its request; late valid is ignored; port 3 next.
        @(posedge clk);
        #1;
        port_enable = 4'b1100;
        wait_mem_en(ok);
        chk("abort_grant", grant, 4'b0100);
        @(posedge clk);
        #1;
        port_enable[2] = 1'b0;
        @(negedge clk);
        chk("abort_mem_enable", mem_enable, 0);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        @(negedge clk);
        chk("abort_late_valid", port_valid, 0);
        chk("abort_idle_grant", grant, 0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        wait_mem_en(ok);
        chk("abort_next_grant", grant, 4'b1000);
        if (ok) serve(2, 32'h3333_3333, 4'b1000);
        port_enable = '0;

        // Timeout without valid: error pulses in the 5th BUSY cycle.
        @(posedge clk);
        #1;
        port_enable = 4'b0001;
        wait_mem_en(ok);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk("timeout_no_early_error", port_error, 0);
        end
        @(posedge clk);
        #1;
        sb.push_back('{valid: '0, err: 4'b0001, rdata: '0});
        @(negedge clk);
        chk("timeout_busy_last_cycle", busy, 1);
        @(posedge clk);
        #1;
        port_enable = '0;
        @(negedge clk);
        chk("timeout_idle", busy, 0);

        // Reset mid-BUSY on port 1; afterwards port 0 must win.
        @(posedge clk);
        #1;
        port_enable = 4'b0010;
        wait_mem_en(ok);
        chk("rst_pre_grant", grant, 4'b0010);
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        port_enable = 4'b0011;
        #1;
        chk("rst_async_grant", grant, 0);
        chk("rst_async_mem_enable", mem_enable, 0);
        chk("rst_async_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_mem_en(ok);
        chk("rst_first_grant", grant, 4'b0001);
        if (ok) serve(1, 32'h4444_4444, 4'b0001);
        port_enable = '0;

        // Valid on the timeout cycle wins over the error.
        @(posedge clk);
        #1;
        port_enable = 4'b0010;
        wait_mem_en(ok);
        if (ok) serve(4, 32'h5A5A_0005, 4'b0010);
        port_enable = '0;
        @(negedge clk);
        chk("timeout_valid_idle", busy, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
